// File: rtl/reg_bank_add_seq_pkg.sv
// ---------------------------------------------------------------------------
// reg_bank_pkg
//   Shared definitions for the reg_bank_add_seq slice: data width, bank size,
//   operation codes and FSM state encodings.
//   Optional feature macro used by this slice: REG_BANK_ZERO_REG_EN
//   (R0 hard-wired to zero when defined).
// ---------------------------------------------------------------------------
package reg_bank_pkg;

  localparam int DW    = 32;
  localparam int NREGS = 8;
  localparam int AW    = $clog2(NREGS);

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADDC = 2'b10,
    OP_LDI  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    EXEC = 2'b10,
    WB   = 2'b11
  } state_e;

endpackage

// File: rtl/reg_bank_add_seq_if.sv
// ---------------------------------------------------------------------------
// reg_bank_add_seq_if
//   Request/response and debug-read bundle of reg_bank_add_seq.
//   Request : start_i, op_i, rs1_i, rs2_i, rd_i, imm_i
//   Status  : busy_o, done_o, result_o, carry_o
//   Debug   : dbg_addr_i -> dbg_data_o (combinational register read)
//   slave  modport: the sequencer; master modport: whoever issues operations.
//   Optional feature macro of this slice: REG_BANK_ZERO_REG_EN (no effect here).
// ---------------------------------------------------------------------------
interface reg_bank_add_seq_if;
  import reg_bank_pkg::*;

  logic          start_i;
  logic [1:0]    op_i;
  logic [AW-1:0] rs1_i;
  logic [AW-1:0] rs2_i;
  logic [AW-1:0] rd_i;
  logic [DW-1:0] imm_i;
  logic          busy_o;
  logic          done_o;
  logic [DW-1:0] result_o;
  logic          carry_o;
  logic [AW-1:0] dbg_addr_i;
  logic [DW-1:0] dbg_data_o;

  modport slave (
    input  start_i, op_i, rs1_i, rs2_i, rd_i, imm_i, dbg_addr_i,
    output busy_o, done_o, result_o, carry_o, dbg_data_o
  );

  modport master (
    output start_i, op_i, rs1_i, rs2_i, rd_i, imm_i, dbg_addr_i,
    input  busy_o, done_o, result_o, carry_o, dbg_data_o
  );

endinterface

// File: rtl/reg_bank_add_seq_adder.sv
// ---------------------------------------------------------------------------
// Adder_32
//   The team's 32-bit ripple-carry adder: c_o = a_i + b_i + cin_i (mod 2^32),
//   cout_o is the carry out of the top bit. Purely combinational.
//   Ports: a_i, b_i (DW), cin_i -> c_o (DW), cout_o.
//   Optional feature macro of this slice: REG_BANK_ZERO_REG_EN (no effect here).
// ---------------------------------------------------------------------------
module Adder_32
  import reg_bank_pkg::*;
(
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic          cin_i,
  output logic [DW-1:0] c_o,
  output logic          cout_o
);

  logic [DW:0] carryChain;

  // Bit-serial ripple: each stage is a full adder fed by the previous carry.
  always_comb begin
    carryChain    = '0;
    carryChain[0] = cin_i;
    c_o           = '0;
    for (int i = 0; i < DW; i++) begin
      c_o[i]          = a_i[i] ^ b_i[i] ^ carryChain[i];
      carryChain[i+1] = (a_i[i] & b_i[i]) | (carryChain[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = carryChain[DW];
  end

endmodule

// File: rtl/reg_bank_add_seq.sv
// ---------------------------------------------------------------------------
// reg_bank_add_seq
//   8 x 32-bit register bank sequenced around Adder_32. A request is latched
//   in IDLE, operands are read in READ, the adder result is registered in
//   EXEC and written back (bank, result, carry flag, done pulse) in WB.
//   Ports: clk, rst_n (async, active-low), bus (reg_bank_add_seq_if.slave).
//   Optional feature macro: REG_BANK_ZERO_REG_EN -- R0 always reads 0 and
//   writes to it are dropped; result/carry/done still update.
// ---------------------------------------------------------------------------
module reg_bank_add_seq
  import reg_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  reg_bank_add_seq_if.slave bus
);

  state_e        state_q, state_d;
  logic [1:0]    op_q;
  logic [AW-1:0] rs1_q, rs2_q, rd_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] a_q, b_q, sum_q, result_q;
  logic          cin_q, cout_q, carry_q, busy_q, done_q;
  logic [DW-1:0] regs_q [NREGS];

  logic          accept, writeBack, bankWe;
  logic [DW-1:0] a_d, b_d, adderSum;
  logic          cin_d, adderCout;

  // FSM next state. WB takes a waiting start directly into READ so that a
  // request arriving on the write-back edge is not lost and back-to-back
  // operations run at one per three cycles.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    writeBack = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          accept  = 1'b1;
          state_d = READ;
        end
      end
      READ: state_d = EXEC;
      EXEC: state_d = WB;
      WB: begin
        writeBack = 1'b1;
        if (bus.start_i) begin
          accept  = 1'b1;
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand and carry-in selection from the latched request.
  always_comb begin
    a_d   = regs_q[rs1_q];
    b_d   = regs_q[rs2_q];
    cin_d = 1'b0;
    case (op_e'(op_q))
      OP_SUB: begin
        b_d   = ~regs_q[rs2_q];
        cin_d = 1'b1;
      end
      OP_ADDC: cin_d = carry_q;
      OP_LDI: begin
        a_d = imm_q;
        b_d = '0;
      end
      default: ;
    endcase
  end

`ifdef REG_BANK_ZERO_REG_EN
  // R0 is never written, so it keeps its reset value of zero.
  assign bankWe = writeBack && (rd_q != '0);
`else
  assign bankWe = writeBack;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= writeBack;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= bus.op_i;
        rs1_q <= bus.rs1_i;
        rs2_q <= bus.rs2_i;
        rd_q  <= bus.rd_i;
        imm_q <= bus.imm_i;
      end
      if (state_q == READ) begin
        a_q   <= a_d;
        b_q   <= b_d;
        cin_q <= cin_d;
      end
      if (state_q == EXEC) begin
        sum_q  <= adderSum;
        cout_q <= adderCout;
      end
      if (writeBack) begin
        result_q <= sum_q;
        if (op_e'(op_q) != OP_LDI) begin
          carry_q <= cout_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (bankWe) begin
      regs_q[rd_q] <= sum_q;
    end
  end

  Adder_32 u_adder (
    .a_i    (a_q),
    .b_i    (b_q),
    .cin_i  (cin_q),
    .c_o    (adderSum),
    .cout_o (adderCout)
  );

  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.result_o   = result_q;
  assign bus.carry_o    = carry_q;
  assign bus.dbg_data_o = regs_q[bus.dbg_addr_i];

endmodule

// File: tb/tb_reg_bank_add_seq.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_add_seq
//   Self-checking bench for reg_bank_add_seq: a table of single operations
//   with hand-computed expectations, plus hand-written sequences for held
//   start, reset during EXEC and the R0 behaviour (REG_BANK_ZERO_REG_EN).
// ---------------------------------------------------------------------------
module tb_reg_bank_add_seq;
  import reg_bank_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  reg_bank_add_seq_if bus ();

  reg_bank_add_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [2:0]  rd;
    logic [31:0] imm;
    logic [31:0] expResult;
    logic        expCarry;
  } vec_t;

  typedef struct {
    logic [31:0] result;
    logic        carry;
    logic [2:0]  rd;
    logic [31:0] dbg;
  } exp_t;

  vec_t vecs [16];
  exp_t sbQ [$];
  int   checks = 0;
  int   errors = 0;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Pop the oldest expected write-back and compare it against the DUT.
  task automatic checkOutput();
    exp_t e;
    if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboardEmpty: actual=done with no pending op expected=pending op");
      return;
    end
    e = sbQ.pop_front();
    checkVal("result", bus.result_o, e.result);
    checkVal("carry", {31'b0, bus.carry_o}, {31'b0, e.carry});
    bus.dbg_addr_i = e.rd;
    #1;
    checkVal("dbgData", bus.dbg_data_o, e.dbg);
  endtask

  // Bounded wait for done; cyc counts edges after the start edge.
  task automatic waitDone(output int cyc);
    bit found;
    found = 1'b0;
    cyc   = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done_o) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL doneTimeout: actual=no done in 8 cycles expected=done");
    end
  endtask

  // Issue one operation, scramble the request inputs afterwards (they must
  // have been latched), then check latency, write-back and pulse width.
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                               input logic [2:0] rd, input logic [31:0] imm,
                               input logic [31:0] expResult, input logic expCarry,
                               input logic [31:0] expDbg);
    int cyc;
    @(negedge clk);
    bus.op_i    = op;
    bus.rs1_i   = rs1;
    bus.rs2_i   = rs2;
    bus.rd_i    = rd;
    bus.imm_i   = imm;
    bus.start_i = 1'b1;
    sbQ.push_back('{result: expResult, carry: expCarry, rd: rd, dbg: expDbg});
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.op_i    = 2'($urandom_range(0, 3));
    bus.rs1_i   = 3'($urandom_range(0, 7));
    bus.rs2_i   = 3'($urandom_range(0, 7));
    bus.rd_i    = 3'($urandom_range(0, 7));
    bus.imm_i   = $urandom;
    checkVal("busyAfterStart", {31'b0, bus.busy_o}, 32'd1);
    waitDone(cyc);
    checkVal("doneLatency", 32'(cyc), 32'd3);
    checkOutput();
    checkVal("busyAfterDone", {31'b0, bus.busy_o}, 32'd0);
    @(posedge clk);
    #1;
    checkVal("donePulseWidth", {31'b0, bus.done_o}, 32'd0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkVal({tag, "Busy"}, {31'b0, bus.busy_o}, 32'd0);
    checkVal({tag, "Done"}, {31'b0, bus.done_o}, 32'd0);
    checkVal({tag, "Result"}, bus.result_o, 32'd0);
    checkVal({tag, "Carry"}, {31'b0, bus.carry_o}, 32'd0);
    for (int r = 0; r < 8; r++) begin
      bus.dbg_addr_i = 3'(r);
      #1;
      checkVal({tag, "Dbg"}, bus.dbg_data_o, 32'd0);
    end
  endtask

  // Watchdog so the run always ends even if the DUT wedges.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int doneSeen;
    logic [31:0] zeroDbg;

    rst_n          = 1'b0;
    bus.start_i    = 1'b0;
    bus.op_i       = '0;
    bus.rs1_i      = '0;
    bus.rs2_i      = '0;
    bus.rd_i       = '0;
    bus.imm_i      = '0;
    bus.dbg_addr_i = '0;

    //              op       rs1   rs2   rd    imm            result         carry
    vecs[0]  = '{OP_LDI,  3'd0, 3'd0, 3'd1, 32'h0000_0005, 32'h0000_0005, 1'b0};
    vecs[1]  = '{OP_LDI,  3'd0, 3'd0, 3'd2, 32'h0000_0003, 32'h0000_0003, 1'b0};
    vecs[2]  = '{OP_ADD,  3'd1, 3'd2, 3'd3, 32'h0,         32'h0000_0008, 1'b0};
    vecs[3]  = '{OP_LDI,  3'd0, 3'd0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{OP_LDI,  3'd0, 3'd0, 3'd2, 32'h0000_0001, 32'h0000_0001, 1'b0};
    vecs[5]  = '{OP_ADD,  3'd1, 3'd2, 3'd4, 32'h0,         32'h0000_0000, 1'b1};
    vecs[6]  = '{OP_LDI,  3'd0, 3'd0, 3'd1, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[7]  = '{OP_LDI,  3'd0, 3'd0, 3'd2, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[8]  = '{OP_ADDC, 3'd1, 3'd2, 3'd5, 32'h0,         32'h0000_0001, 1'b0};
    vecs[9]  = '{OP_LDI,  3'd0, 3'd0, 3'd1, 32'h0000_0003, 32'h0000_0003, 1'b0};
    vecs[10] = '{OP_LDI,  3'd0, 3'd0, 3'd2, 32'h0000_0005, 32'h0000_0005, 1'b0};
    vecs[11] = '{OP_SUB,  3'd1, 3'd2, 3'd6, 32'h0,         32'hFFFF_FFFE, 1'b0};
    vecs[12] = '{OP_SUB,  3'd2, 3'd1, 3'd7, 32'h0,         32'h0000_0002, 1'b1};
    vecs[13] = '{OP_LDI,  3'd0, 3'd0, 3'd1, 32'h0000_0007, 32'h0000_0007, 1'b1};
    vecs[14] = '{OP_LDI,  3'd0, 3'd0, 3'd2, 32'h0000_0001, 32'h0000_0001, 1'b1};
    vecs[15] = '{OP_ADD,  3'd1, 3'd2, 3'd1, 32'h0,         32'h0000_0008, 1'b0};

    // Reset state: all outputs and every register read back as zero.
    repeat (2) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single operations.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].imm,
                    vecs[i].expResult, vecs[i].expCarry, vecs[i].expResult);
    end

    // start held high: R1 = R1 + R2 (8 + 1) three times, one op per 3 cycles.
    @(negedge clk);
    bus.op_i    = OP_ADD;
    bus.rs1_i   = 3'd1;
    bus.rs2_i   = 3'd2;
    bus.rd_i    = 3'd1;
    bus.start_i = 1'b1;
    sbQ.push_back('{result: 32'd9,  carry: 1'b0, rd: 3'd1, dbg: 32'd9});
    sbQ.push_back('{result: 32'd10, carry: 1'b0, rd: 3'd1, dbg: 32'd10});
    sbQ.push_back('{result: 32'd11, carry: 1'b0, rd: 3'd1, dbg: 32'd11});
    doneSeen = 0;
    for (k = 0; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 6) bus.start_i = 1'b0;
      checkVal("heldBusy", {31'b0, bus.busy_o}, (k < 9) ? 32'd1 : 32'd0);
      if (bus.done_o) begin
        doneSeen++;
        checkVal("heldDoneCycle", 32'(k), 32'(3 * doneSeen));
        checkOutput();
      end
    end
    checkVal("heldDoneCount", 32'(doneSeen), 32'd3);

    // Reset during EXEC of ADD R3 = R1 + R2 aborts with no write.
    applyStimulus(OP_LDI, 3'd0, 3'd0, 3'd1, 32'd5, 32'd5, 1'b0, 32'd5);
    applyStimulus(OP_LDI, 3'd0, 3'd0, 3'd2, 32'd3, 32'd3, 1'b0, 32'd3);
    @(negedge clk);
    bus.op_i    = OP_ADD;
    bus.rs1_i   = 3'd1;
    bus.rs2_i   = 3'd2;
    bus.rd_i    = 3'd3;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    checkVal("busyBeforeAbort", {31'b0, bus.busy_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("abort");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkVal("noDoneAfterAbort", {31'b0, bus.done_o}, 32'd0);
    end
    bus.dbg_addr_i = 3'd3;
    #1;
    checkVal("r3AfterAbort", bus.dbg_data_o, 32'd0);
    applyStimulus(OP_LDI, 3'd0, 3'd0, 3'd4, 32'h55, 32'h55, 1'b0, 32'h55);

    // R0 behaviour depends on the zero-register build option.
`ifdef REG_BANK_ZERO_REG_EN
    zeroDbg = 32'h0;
`else
    zeroDbg = 32'h1234;
`endif
    applyStimulus(OP_LDI, 3'd0, 3'd0, 3'd0, 32'h1234, 32'h1234, 1'b0, zeroDbg);

    checkVal("scoreboardDrained", 32'(sbQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
